// File: rtl/rvj1_timer_irq.sv
// rvj1_timer_irq: compare/interrupt stage behind the rvj1 SoC timer.
// Raises a level interrupt when time_i enters equality with CMP and counts
// matches. Registers are reached through a Wishbone classic slave port.
module rvj1_timer_irq #(
  parameter int unsigned TW   = 32,
  parameter int unsigned CNTW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [TW-1:0] time_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [1:0]    wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          irq_o
);

  typedef enum logic [1:0] {
    REG_CMP    = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_MCNT   = 2'd3
  } reg_e;

  reg_e            reg_sel;
  logic [TW-1:0]   cmp;
  logic            en;
  logic            ie;
  logic            oneshot;
  logic            pend;
  logic [CNTW-1:0] mcnt;
  logic            eq;
  logic            eq_q;
  logic            hit;
  logic            req;
  logic            wr;
  logic            ack;
  logic [31:0]     dat;
  logic [31:0]     cmp_merge;
  logic [31:0]     rd_data;

  assign reg_sel = reg_e'(wb_adr_i);

  // A new request is only accepted while no ack is outstanding
  assign req = wb_cyc_i & wb_stb_i & ~ack;
  assign wr  = req & wb_we_i;

  // Match fires once per entry into equality
  assign eq  = en & (time_i == cmp);
  assign hit = eq & ~eq_q;

  // Byte-lane merge of write data into the current compare value
  always_comb begin
    cmp_merge = 32'(cmp);
    for (int unsigned b = 0; b < 4; b++) begin
      if (wb_sel_i[b]) begin
        cmp_merge[8*b +: 8] = wb_dat_i[8*b +: 8];
      end
    end
  end

  // Read multiplexer; unused bits read as zero
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CMP:    rd_data = 32'(cmp);
      REG_CTRL:   rd_data[2:0] = {oneshot, ie, en};
      REG_STATUS: rd_data[0] = pend;
      REG_MCNT:   rd_data = 32'(mcnt);
    endcase
  end

  // Single-cycle acknowledge and registered read data
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack <= 1'b0;
      dat <= '0;
    end else begin
      ack <= req;
      if (req) begin
        dat <= rd_data;
      end
    end
  end

  // Compare register with byte enables
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmp <= '1;
    end else if (wr && reg_sel == REG_CMP) begin
      cmp <= cmp_merge[TW-1:0];
    end
  end

  // Control bits; a bus write overrides the oneshot auto-clear of EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      oneshot <= 1'b0;
    end else if (wr && reg_sel == REG_CTRL && wb_sel_i[0]) begin
      {oneshot, ie, en} <= wb_dat_i[2:0];
    end else if (hit && oneshot) begin
      en <= 1'b0;
    end
  end

  // Sticky pending flag; a match beats a simultaneous W1C
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend <= 1'b0;
    end else if (hit) begin
      pend <= 1'b1;
    end else if (wr && reg_sel == REG_STATUS && wb_sel_i[0] && wb_dat_i[0]) begin
      pend <= 1'b0;
    end
  end

  // Match counter; any write clears it and beats a simultaneous match
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mcnt <= '0;
    end else if (wr && reg_sel == REG_MCNT) begin
      mcnt <= '0;
    end else if (hit) begin
      mcnt <= mcnt + CNTW'(1);
    end
  end

  // Previous-cycle equality for edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      eq_q <= 1'b0;
    end else begin
      eq_q <= eq;
    end
  end

  assign wb_ack_o = ack;
  assign wb_dat_o = dat;
  assign irq_o    = pend & ie;

endmodule

// File: tb/tb_rvj1_timer_irq.sv
// Bench for rvj1_timer_irq: per-cycle reference model plus directed scenarios
// with literal expectations on register reads and irq.
module tb_rvj1_timer_irq;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] time_v = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  rvj1_timer_irq #(.TW(32), .CNTW(8)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .time_i   (time_v),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_sel_i (sel),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack_o),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  // Reference model state: register contents plus bus/edge history
  typedef struct packed {
    logic [31:0] cmp;
    logic [2:0]  ctrl;
    logic        pend;
    logic [7:0]  mcnt;
    logic        prev_eq;
    logic        ack;
    logic [31:0] dat;
  } mstate_t;

  localparam mstate_t M_RESET = '{cmp: 32'hFFFF_FFFF, ctrl: 3'd0, pend: 1'b0,
                                  mcnt: 8'd0, prev_eq: 1'b0, ack: 1'b0, dat: 32'd0};

  mstate_t m;

  // Next state from the register rules: match effects first, then the bus
  // write (write wins), then the sticky set (set wins over W1C).
  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    logic now_eq, hit, req, wr;
    n      = s;
    now_eq = s.ctrl[0] && (time_v == s.cmp);
    hit    = now_eq && !s.prev_eq;
    req    = cyc && stb && !s.ack;
    wr     = req && we;
    if (req) begin
      case (adr)
        2'd0:    n.dat = s.cmp;
        2'd1:    n.dat = {29'd0, s.ctrl};
        2'd2:    n.dat = {31'd0, s.pend};
        default: n.dat = {24'd0, s.mcnt};
      endcase
    end
    if (hit) begin
      n.mcnt = s.mcnt + 8'd1;
      if (s.ctrl[2]) n.ctrl[0] = 1'b0;
    end
    if (wr) begin
      case (adr)
        2'd0: for (int b = 0; b < 4; b++) if (sel[b]) n.cmp[8*b +: 8] = dat[8*b +: 8];
        2'd1: if (sel[0]) n.ctrl = dat[2:0];
        2'd2: if (sel[0] && dat[0]) n.pend = 1'b0;
        default: n.mcnt = 8'd0;
      endcase
    end
    if (hit) n.pend = 1'b1;
    n.prev_eq = now_eq;
    n.ack     = req;
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= M_RESET;
    else       m <= model_next(m);
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    vectors++;
    if (ack_o !== m.ack) begin
      miscompares++;
      $display("FAIL ack_cycle t=%0t got %b want %b", $time, ack_o, m.ack);
    end
    vectors++;
    if (irq !== (m.pend & m.ctrl[1])) begin
      miscompares++;
      $display("FAIL irq_cycle t=%0t got %b want %b", $time, irq, m.pend & m.ctrl[1]);
    end
    vectors++;
    if (dat_o !== m.dat) begin
      miscompares++;
      $display("FAIL dat_cycle t=%0t got %h want %h", $time, dat_o, m.dat);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, got, exp);
    end
  endtask

  task automatic tick(input logic [31:0] t);
    time_v = t;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] t = lo; t <= hi; t++) tick(t);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(posedge clk);
    #1;
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Reset defaults and a quiet sweep
    read_check("rst_cmp", 2'd0, 32'hFFFF_FFFF);
    read_check("rst_ctrl", 2'd1, 32'h0);
    read_check("rst_status", 2'd2, 32'h0);
    read_check("rst_mcnt", 2'd3, 32'h0);
    sweep(32'h0, 32'h15);
    check("rst_irq_quiet", {31'd0, irq}, 32'h0);

    // Byte-enable merge into CMP
    bus_write(2'd0, 32'h1234_5678, 4'b0011);
    read_check("cmp_bytesel", 2'd0, 32'hFFFF_5678);

    // Periodic match over four wraps
    time_v = '0;
    bus_write(2'd0, 32'h15, 4'hF);
    bus_write(2'd1, 32'h3, 4'hF);
    for (int w = 0; w < 4; w++) begin
      sweep(32'h0, 32'h15);
      check("periodic_irq_hi", {31'd0, irq}, 32'h1);
      time_v = '0;
      bus_write(2'd2, 32'h1, 4'hF);
      check("periodic_irq_lo", {31'd0, irq}, 32'h0);
    end
    read_check("periodic_mcnt", 2'd3, 32'h4);

    // Stalled timer holds the compare value
    bus_write(2'd3, 32'h0, 4'hF);
    sweep(32'h0, 32'h14);
    repeat (10) tick(32'h15);
    check("stall_irq", {31'd0, irq}, 32'h1);
    read_check("stall_mcnt", 2'd3, 32'h1);
    bus_write(2'd2, 32'h0, 4'hF);
    read_check("stall_w0_noeffect", 2'd2, 32'h1);
    time_v = '0;
    bus_write(2'd2, 32'h1, 4'hF);

    // Oneshot
    bus_write(2'd3, 32'h0, 4'hF);
    bus_write(2'd0, 32'h5, 4'hF);
    bus_write(2'd1, 32'h7, 4'hF);
    sweep(32'h0, 32'h15);
    read_check("oneshot_ctrl", 2'd1, 32'h6);
    read_check("oneshot_mcnt1", 2'd3, 32'h1);
    bus_write(2'd2, 32'h1, 4'hF);
    sweep(32'h0, 32'h15);
    read_check("oneshot_nopend", 2'd2, 32'h0);
    read_check("oneshot_mcnt2", 2'd3, 32'h1);

    // W1C ack edge coincides with the match edge
    time_v = '0;
    bus_write(2'd3, 32'h0, 4'hF);
    bus_write(2'd1, 32'h3, 4'hF);
    sweep(32'h0, 32'h4);
    time_v = 32'h5;
    bus_write(2'd2, 32'h1, 4'hF);
    check("collide_irq", {31'd0, irq}, 32'h1);
    read_check("collide_pend", 2'd2, 32'h1);
    read_check("collide_mcnt", 2'd3, 32'h1);
    time_v = '0;
    bus_write(2'd2, 32'h1, 4'hF);
    check("w1c_irq_lo", {31'd0, irq}, 32'h0);
    read_check("w1c_pend", 2'd2, 32'h0);

    // Asynchronous reset during a write ack with PEND set
    sweep(32'h0, 32'h5);
    check("pre_reset_irq", {31'd0, irq}, 32'h1);
    time_v = '0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; dat = 32'h1234; sel = 4'hF;
    @(posedge clk);
    #1;
    check("pre_reset_ack", {31'd0, ack_o}, 32'h1);
    #1 rstn = 1'b0;
    #1;
    check("reset_ack", {31'd0, ack_o}, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    read_check("post_rst_cmp", 2'd0, 32'hFFFF_FFFF);
    read_check("post_rst_ctrl", 2'd1, 32'h0);
    read_check("post_rst_status", 2'd2, 32'h0);
    read_check("post_rst_mcnt", 2'd3, 32'h0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
